// File: rtl/alu16_pkg.sv
// alu16_pkg
// Shared definitions for the 16-bit execute-stage controller and its
// register file: datapath widths, ALU op encoding and the controller FSM
// state type.
package alu16_pkg;

  localparam int DATA_W   = 16;
  localparam int IDX_W    = 3;
  localparam int NUM_REGS = 1 << IDX_W;

  // ALU operation encoding; the controller forwards these untouched.
  localparam logic [2:0] ALU16_ADD = 3'd0;
  localparam logic [2:0] ALU16_SUB = 3'd1;
  localparam logic [2:0] ALU16_AND = 3'd2;
  localparam logic [2:0] ALU16_OR  = 3'd3;
  localparam logic [2:0] ALU16_XOR = 3'd4;
  localparam logic [2:0] ALU16_MOV = 3'd5;
  localparam logic [2:0] ALU16_SHL = 3'd6;
  localparam logic [2:0] ALU16_SHR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

endpackage

// File: rtl/alu16_regfile.sv
// alu16_regfile
// 8 x 16 architectural register file.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   wrEn_i/wrAddr_i/wrData_i  single synchronous write port
//   rdAddrA_i/rdDataA_o   combinational read port for ALU operand a
//   rdAddrB_i/rdDataB_o   combinational read port for ALU operand b
//   dbgAddr_i/dbgData_o   combinational debug read port
module alu16_regfile
  import alu16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn_i,
  input  logic [IDX_W-1:0]  wrAddr_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  logic [IDX_W-1:0]  rdAddrA_i,
  output logic [DATA_W-1:0] rdDataA_o,
  input  logic [IDX_W-1:0]  rdAddrB_i,
  output logic [DATA_W-1:0] rdDataB_o,
  input  logic [IDX_W-1:0]  dbgAddr_i,
  output logic [DATA_W-1:0] dbgData_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Register storage: reset wins over a write in the same cycle, so an
  // instruction aborted by reset in its WB cycle leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wrEn_i) begin
      regs_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdDataA_o = regs_q[rdAddrA_i];
  assign rdDataB_o = regs_q[rdAddrB_i];
  assign dbgData_o = regs_q[dbgAddr_i];

endmodule

// File: rtl/alu16_exec_ctrl.sv
// alu16_exec_ctrl
// Execute-stage controller for an external combinational 16-bit ALU.
// Accepts one instruction per handshake in IDLE, drives the ALU from the
// latched fields during EXEC, registers the ALU result and flags, and
// commits them to the register file and flags register in WB.
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   in_valid/in_ready          instruction handshake (ready only in IDLE)
//   in_op/in_dst/in_src        op, destination (= operand a), operand b index
//   in_use_imm/in_imm          immediate select and value for operand b
//   in_nowb                    flags-only instruction (ALU16_CMP_EN builds)
//   alu_op/alu_a/alu_b         operands to the ALU
//   alu_y/alu_zf/alu_cf/alu_sf ALU result and flags
//   zf/cf/sf                   architectural flags register
//   done                       one-cycle pulse during WB
//   dbg_addr/dbg_data          combinational register file read
// Configuration macro: ALU16_CMP_EN adds in_nowb (register write suppress).
module alu16_exec_ctrl
  import alu16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [IDX_W-1:0]  in_dst,
  input  logic [IDX_W-1:0]  in_src,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
`ifdef ALU16_CMP_EN
  input  logic              in_nowb,
`endif
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_zf,
  input  logic              alu_cf,
  input  logic              alu_sf,
  output logic              zf,
  output logic              cf,
  output logic              sf,
  output logic              done,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e state_q, state_d;

  logic [2:0]        op_q;
  logic [IDX_W-1:0]  dst_q;
  logic [IDX_W-1:0]  src_q;
  logic              useImm_q;
  logic [DATA_W-1:0] imm_q;

  logic [DATA_W-1:0] resY_q;
  logic              resZf_q, resCf_q, resSf_q;
  logic              zf_q, cf_q, sf_q;

  logic              wrEn;
  logic [DATA_W-1:0] rdA, rdB;
  logic              accept;

  assign accept = (state_q == IDLE) && in_valid;

  // State register; reset returns to IDLE from anywhere, abandoning any
  // instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs: a fixed three-cycle walk
  // IDLE -> EXEC -> WB -> IDLE per accepted instruction.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = EXEC;
      end
      EXEC: state_d = WB;
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Instruction fields are captured once on accept and held until the next
  // accept, so the ALU inputs stay stable through EXEC and WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= ALU16_ADD;
      dst_q    <= '0;
      src_q    <= '0;
      useImm_q <= 1'b0;
      imm_q    <= '0;
    end else if (accept) begin
      op_q     <= in_op;
      dst_q    <= in_dst;
      src_q    <= in_src;
      useImm_q <= in_use_imm;
      imm_q    <= in_imm;
    end
  end

`ifdef ALU16_CMP_EN
  logic nowb_q;

  // Flags-only marker travels with the rest of the instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      nowb_q <= 1'b0;
    end else if (accept) begin
      nowb_q <= in_nowb;
    end
  end

  assign wrEn = (state_q == WB) && !nowb_q;
`else
  assign wrEn = (state_q == WB);
`endif

  // ALU result is registered at the end of EXEC so nothing downstream sees
  // a combinational path from the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      resY_q  <= '0;
      resZf_q <= 1'b0;
      resCf_q <= 1'b0;
      resSf_q <= 1'b0;
    end else if (state_q == EXEC) begin
      resY_q  <= alu_y;
      resZf_q <= alu_zf;
      resCf_q <= alu_cf;
      resSf_q <= alu_sf;
    end
  end

  // Architectural flags commit in WB for every instruction, including MOV
  // and flags-only ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b0;
      cf_q <= 1'b0;
      sf_q <= 1'b0;
    end else if (state_q == WB) begin
      zf_q <= resZf_q;
      cf_q <= resCf_q;
      sf_q <= resSf_q;
    end
  end

  alu16_regfile uRegfile (
    .clk       (clk),
    .rst       (rst),
    .wrEn_i    (wrEn),
    .wrAddr_i  (dst_q),
    .wrData_i  (resY_q),
    .rdAddrA_i (dst_q),
    .rdDataA_o (rdA),
    .rdAddrB_i (src_q),
    .rdDataB_o (rdB),
    .dbgAddr_i (dbg_addr),
    .dbgData_o (dbg_data)
  );

  assign alu_op = op_q;
  assign alu_a  = rdA;
  assign alu_b  = useImm_q ? imm_q : rdB;

  assign zf = zf_q;
  assign cf = cf_q;
  assign sf = sf_q;

endmodule

// File: tb/tb_alu16_exec_ctrl.sv
// tb_alu16_exec_ctrl
// Directed bench for alu16_exec_ctrl with a behavioural combinational ALU
// attached to the alu_* ports. Works with or without ALU16_CMP_EN.
module tb_alu16_exec_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_dst;
  logic [2:0]  in_src;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic        in_nowb;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_y;
  logic        alu_zf;
  logic        alu_cf;
  logic        alu_sf;
  logic        zf, cf, sf;
  logic        done;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int compCount = 0;
  int errCount  = 0;

  alu16_exec_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_dst     (in_dst),
    .in_src     (in_src),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
`ifdef ALU16_CMP_EN
    .in_nowb    (in_nowb),
`endif
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .alu_zf     (alu_zf),
    .alu_cf     (alu_cf),
    .alu_sf     (alu_sf),
    .zf         (zf),
    .cf         (cf),
    .sf         (sf),
    .done       (done),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: carry is carry-out for ADD, borrow for SUB, the last
  // bit shifted out for shifts, and 0 for logic ops and MOV.
  always_comb begin
    logic [16:0] wide;
    wide   = '0;
    alu_cf = 1'b0;
    alu_y  = '0;
    case (alu_op)
      3'd0: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_y = wide[15:0]; alu_cf = wide[16]; end
      3'd1: begin wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_y = wide[15:0]; alu_cf = wide[16]; end
      3'd2: alu_y = alu_a & alu_b;
      3'd3: alu_y = alu_a | alu_b;
      3'd4: alu_y = alu_a ^ alu_b;
      3'd5: alu_y = alu_b;
      3'd6: begin wide = {1'b0, alu_a} << alu_b[3:0]; alu_y = wide[15:0]; alu_cf = wide[16]; end
      default: begin wide = {alu_a, 1'b0} >> alu_b[3:0]; alu_y = wide[16:1]; alu_cf = wide[0]; end
    endcase
    alu_zf = (alu_y == 16'h0000);
    alu_sf = alu_y[15];
  end

  // Single comparison point: counts, and reports a mismatch with tag.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkFlags(input string tag, input logic expZf,
                            input logic expCf, input logic expSf);
    checkOutput({tag, "_zf"}, {15'd0, zf}, {15'd0, expZf});
    checkOutput({tag, "_cf"}, {15'd0, cf}, {15'd0, expCf});
    checkOutput({tag, "_sf"}, {15'd0, sf}, {15'd0, expSf});
  endtask

  task automatic readReg(input string tag, input logic [2:0] idx,
                         input logic [15:0] expected);
    @(negedge clk);
    dbg_addr = idx;
    #1;
    checkOutput(tag, dbg_data, expected);
  endtask

  // Issues one instruction and checks the whole accept/EXEC/WB/commit
  // timeline, including the old-then-new register read around WB.
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [2:0] dst, input logic [2:0] src,
                               input logic useImm, input logic [15:0] imm,
                               input logic nowb, input logic [15:0] oldVal,
                               input logic [15:0] newVal, input logic expZf,
                               input logic expCf, input logic expSf);
    @(negedge clk);
    in_valid   = 1'b1;
    in_op      = op;
    in_dst     = dst;
    in_src     = src;
    in_use_imm = useImm;
    in_imm     = imm;
    in_nowb    = nowb;
    dbg_addr   = dst;
    checkOutput({tag, "_rdyIdle"}, {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput({tag, "_rdyExec"}, {15'd0, in_ready}, 16'd0);
    checkOutput({tag, "_doneExec"}, {15'd0, done}, 16'd0);
    checkOutput({tag, "_aluOp"}, {13'd0, alu_op}, {13'd0, op});
    @(negedge clk);
    checkOutput({tag, "_rdyWb"}, {15'd0, in_ready}, 16'd0);
    checkOutput({tag, "_doneWb"}, {15'd0, done}, 16'd1);
    checkOutput({tag, "_dbgOld"}, dbg_data, oldVal);
    @(negedge clk);
    checkOutput({tag, "_rdyAfter"}, {15'd0, in_ready}, 16'd1);
    checkOutput({tag, "_doneAfter"}, {15'd0, done}, 16'd0);
    checkOutput({tag, "_dbgNew"}, dbg_data, newVal);
    checkFlags(tag, expZf, expCf, expSf);
  endtask

  initial begin
    int lastAcc;
    int k;
    int doneCnt;
    logic acc;
    logic [15:0] b2bImm [3];

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_op      = '0;
    in_dst     = '0;
    in_src     = '0;
    in_use_imm = 1'b0;
    in_imm     = '0;
    in_nowb    = 1'b0;
    dbg_addr   = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("rst_done", {15'd0, done}, 16'd0);
    checkOutput("rst_aluOp", {13'd0, alu_op}, 16'd0);
    checkOutput("rst_aluA", alu_a, 16'h0000);
    checkOutput("rst_aluB", alu_b, 16'h0000);
    checkFlags("rst", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      readReg($sformatf("rst_R%0d", i), 3'(i), 16'h0000);
    end

    // MOV R1,#FFFF then ADD R1,#0001 wraps to zero with carry
    applyStimulus("movR1", 3'd5, 3'd1, 3'd0, 1'b1, 16'hFFFF, 1'b0,
                  16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    applyStimulus("addR1", 3'd0, 3'd1, 3'd0, 1'b1, 16'h0001, 1'b0,
                  16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0);

    // MOV R2,#8000 then SHL R2,#1 shifts the sign bit into carry
    applyStimulus("movR2", 3'd5, 3'd2, 3'd0, 1'b1, 16'h8000, 1'b0,
                  16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1);
    applyStimulus("shlR2", 3'd6, 3'd2, 3'd0, 1'b1, 16'h0001, 1'b0,
                  16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0);

    // MOV R3,#1234 then SUB R3,R3 with dst==src
    applyStimulus("movR3", 3'd5, 3'd3, 3'd0, 1'b1, 16'h1234, 1'b0,
                  16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0);
    applyStimulus("subR3", 3'd1, 3'd3, 3'd3, 1'b0, 16'h0000, 1'b0,
                  16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Logic op with immediate, then register-register ADD
    applyStimulus("movR6", 3'd5, 3'd6, 3'd0, 1'b1, 16'h0F0F, 1'b0,
                  16'h0000, 16'h0F0F, 1'b0, 1'b0, 1'b0);
    applyStimulus("orR6", 3'd3, 3'd6, 3'd0, 1'b1, 16'hF000, 1'b0,
                  16'h0F0F, 16'hFF0F, 1'b0, 1'b0, 1'b1);
    applyStimulus("movR7", 3'd5, 3'd7, 3'd0, 1'b1, 16'h0001, 1'b0,
                  16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
    applyStimulus("addR7R6", 3'd0, 3'd7, 3'd6, 1'b0, 16'h0000, 1'b0,
                  16'h0001, 16'hFF10, 1'b0, 1'b0, 1'b1);

`ifdef ALU16_CMP_EN
    // CMP R4,#0007 against R4=0005: flags only, register untouched
    applyStimulus("movR4", 3'd5, 3'd4, 3'd0, 1'b1, 16'h0005, 1'b0,
                  16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0);
    applyStimulus("cmpR4", 3'd1, 3'd4, 3'd0, 1'b1, 16'h0007, 1'b1,
                  16'h0005, 16'h0005, 1'b0, 1'b1, 1'b1);
`endif

    // Reset asserted in the EXEC cycle of MOV R5,#AAAA
    @(negedge clk);
    in_valid   = 1'b1;
    in_op      = 3'd5;
    in_dst     = 3'd5;
    in_src     = 3'd0;
    in_use_imm = 1'b1;
    in_imm     = 16'hAAAA;
    in_nowb    = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("abort_done", {15'd0, done}, 16'd0);
    checkFlags("abort", 1'b0, 1'b0, 1'b0);
    readReg("abort_R5", 3'd5, 16'h0000);
    readReg("abort_R6", 3'd6, 16'h0000);
    repeat (2) @(negedge clk);
    readReg("abort_R5late", 3'd5, 16'h0000);
    applyStimulus("movR5", 3'd5, 3'd5, 3'd0, 1'b1, 16'h0055, 1'b0,
                  16'h0000, 16'h0055, 1'b0, 1'b0, 1'b0);

    // Back-to-back: in_valid held high across three R0 instructions
    b2bImm[0] = 16'h0011;
    b2bImm[1] = 16'h0001;
    b2bImm[2] = 16'h0002;
    lastAcc = -1;
    k       = 0;
    doneCnt = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (k < 3) begin
        in_valid   = 1'b1;
        in_op      = (k == 0) ? 3'd5 : 3'd0;
        in_dst     = 3'd0;
        in_src     = 3'd0;
        in_use_imm = 1'b1;
        in_imm     = b2bImm[k];
        in_nowb    = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (done) doneCnt++;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
        if (lastAcc >= 0) begin
          checkOutput($sformatf("b2b_gap%0d", k), 16'(cyc - lastAcc), 16'd3);
        end
        lastAcc = cyc;
        k++;
      end
    end
    in_valid = 1'b0;
    checkOutput("b2b_accepts", 16'(k), 16'd3);
    checkOutput("b2b_dones", 16'(doneCnt), 16'd3);
    readReg("b2b_R0", 3'd0, 16'h0014);
    checkFlags("b2b", 1'b0, 1'b0, 1'b0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule

// File: doc/alu16_exec_ctrl.md
# alu16_exec_ctrl

Execute-stage controller that sits directly upstream of the 16-bit ALU and consumes its result. Accepts one register/immediate instruction per valid/ready handshake, reads operands from an internal 8×16 register file, drives the combinational ALU, then registers the ALU result and flags and writes them back. Provides the architectural register state and the ZF/CF/SF flags register for the 8086-style datapath.

## Interface
Parameters:
- None.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  controller can accept; high only in IDLE.
- in_op  input  3  ALU operation.
- in_dst  input  3  destination register index; also the source of ALU operand a.
- in_src  input  3  source register index for ALU operand b.
- in_use_imm  input  1  1: operand b = in_imm; 0: operand b = R[in_src].
- in_imm  input  16  immediate operand.
- in_nowb  input  1  flags-only instruction. Present only with ALU16_CMP_EN.
- alu_op  output  3  op to ALU; equals the latched op.
- alu_a  output  16  R[latched dst].
- alu_b  output  16  latched imm or R[latched src].
- alu_y  input  16  ALU result.
- alu_zf  input  1  ALU zero flag.
- alu_cf  input  1  ALU carry flag.
- alu_sf  input  1  ALU sign flag.
- zf  output  1  registered zero flag.
- cf  output  1  registered carry flag.
- sf  output  1  registered sign flag.
- done  output  1  one-cycle pulse in WB.
- dbg_addr  input  3  debug read index.
- dbg_data  output  16  combinational read of R[dbg_addr].

## Operation
- Op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 SHL, 7 SHR. The controller only forwards the op; the ALU computes.
- FSM states: IDLE, EXEC, WB.
- IDLE: in_ready=1. On in_valid, latch op, dst, src, use_imm, imm and nowb, then go to EXEC. in_valid=0 stays in IDLE.
- EXEC: alu_* are driven from the latched fields and the register file. On the clock edge, capture alu_y, zf, cf and sf into result registers, then go to WB.
- WB: done=1. On the clock edge, write R[dst] ← result unless nowb, update the zf/cf/sf registers, then return to IDLE.
- Flags are updated on every instruction, including MOV; the flags register always takes the ALU values.
- dst==src is legal: a and b both read the pre-write value.
- dbg_data shows the old value during the WB cycle and the new value from the following cycle.
- Reset values: state IDLE, all R[0..7]=0, zf=cf=sf=0, done=0, all latched fields 0. alu_op=0, alu_a=0, alu_b=0. in_ready=1 in the first cycle after reset.
- Reset during EXEC or WB aborts the instruction: no register or flag write.
- rst has priority over the handshake in the same cycle.

## Timing
- Accept on edge N (in_valid & in_ready).
- EXEC during cycle N+1; result captured at edge N+1.
- WB during cycle N+2; done=1 and edge N+2 commits.
- New register and flag values are visible from cycle N+3.
- in_ready is 0 during cycles N+1 and N+2; it returns to 1 at N+3.
- Throughput: one instruction per 3 cycles.
- The ALU is purely combinational within the EXEC cycle. No combinational path from alu_* inputs to any output except through registers.

## Configuration
- ALU16_CMP_EN defined:
  - in_nowb port exists.
  - in_nowb=1 suppresses the register write; flags still update. This provides CMP (SUB) and TEST (AND).
- ALU16_CMP_EN undefined:
  - No in_nowb port.
  - Every instruction writes back.

## Structure
- Package alu16_pkg holds:
  - op encoding constants (ALU16_ADD … ALU16_SHR);
  - FSM state enum (IDLE/EXEC/WB);
  - register index width (3) and data width (16).
- One sub-module: alu16_regfile.
  - 8×16 registers, synchronous reset to 0.
  - One synchronous write port.
  - Three combinational read ports: a, b, dbg.

## Test plan
- Reset, then read dbg over 0..7 → all reads 0000; zf=cf=sf=0; in_ready=1.
- MOV R1,#FFFF then ADD R1,#0001 → R1=0000, zf=1, cf=1, sf=0. done pulses 2 cycles after each accept; in_ready is low for 2 cycles after each accept.
- MOV R2,#8000 then SHL R2,#1 → R2=0000, cf=1, zf=1. Then MOV R3,#1234 and SUB R3,R3 (dst==src) → R3=0000, zf=1.
- ALU16_CMP_EN with R4=0005: SUB R4,#0007 with nowb=1 → R4 stays 0005, cf=1, sf=1, zf=0.
- Assert rst in the EXEC cycle of MOV R5,#AAAA → R5=0000 and flags 0; the next instruction is accepted normally.
- Hold in_valid high with back-to-back instructions → exactly one accept every 3 cycles; no instruction is lost or duplicated.
